fma16_norm_round: RTL and testbench

Sequential normalize-and-round back end for the fma16 datapath. It accepts the signed-magnitude wide sum produced by the align-and-sum stage over a valid/ready handshake. It then normalizes the sum iteratively, left for cancellation and right for subnormal results, and rounds to IEEE half precision under the selected rounding mode. It returns the packed 16-bit result with exception flags over a second valid/ready handshake.

---
 rtl/fma16_pkg.sv | 27 ++
 rtl/fma16_lzc.sv | 19 +
 rtl/fma16_norm_round.sv | 183 ++++++++++++++++++
 tb/tb_fma16_norm_round.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fma16_pkg.sv
// fma16 back-end shared types and constants.
// State encoding, rounding modes, IEEE half limits, flag positions.
package fma16_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    OUT
  } state_t;

  localparam logic [1:0] RZ  = 2'b00;
  localparam logic [1:0] RNE = 2'b01;
  localparam logic [1:0] RM  = 2'b10;
  localparam logic [1:0] RP  = 2'b11;

  localparam int BIAS = 15;

  localparam logic [15:0] INF    = 16'h7C00;
  localparam logic [15:0] MAXFIN = 16'h7BFF;

  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

endpackage

// File: rtl/fma16_lzc.sv
// Leading-zero count of the wide sum magnitude.
// An all-zero input reports SUM_W.
module fma16_lzc #(
  parameter  int SUM_W = 48,
  localparam int LW    = $clog2(SUM_W + 1)
) (
  input  logic [SUM_W-1:0] sm_i,
  output logic [LW-1:0]    lzc_o
);

  // Highest set bit wins since it is visited last.
  always_comb begin
    lzc_o = LW'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (sm_i[i]) lzc_o = LW'(SUM_W - 1 - i);
    end
  end

endmodule

// File: rtl/fma16_norm_round.sv
// Iterative normalize and round to IEEE half.
// Valid/ready in, valid/ready out, one op in flight.
module fma16_norm_round
  import fma16_pkg::*;
#(
  parameter int SUM_W = 48,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] sm,
  input  logic signed [7:0] e_in,
  input  logic             ms,
  input  logic [1:0]       roundmode,
  input  logic             special,
  input  logic [15:0]      special_res,
  input  logic [3:0]       special_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      result,
  output logic [3:0]       flags
);

  localparam int LW = $clog2(SUM_W + 1);
  localparam logic signed [7:0] EOVF8 = 8'(2 * BIAS + 1);
  localparam logic signed [8:0] EOVF9 = 9'(2 * BIAS + 1);
  localparam logic [7:0] STEP8 = 8'(STEP);
  localparam logic signed [7:0] ECOL = -8'sd12;

  state_t           state_q;
  logic [SUM_W-1:0] sm_q;
  logic signed [7:0] e_q;
  logic             ms_q;
  logic [1:0]       rm_q;
  logic             sticky_q;
  logic             ovf_q;
  logic [15:0]      result_q;
  logic [3:0]       flags_q;

  logic [LW-1:0] lz;
  logic [7:0]    lz8;
  logic [7:0]    em1;
  logic [7:0]    k_d;

  logic [10:0]       m;
  logic              g;
  logic              s;
  logic              inc;
  logic [11:0]       msum;
  logic [10:0]       m_r;
  logic signed [8:0] e_r;
  logic              zero;
  logic [14:0]       ovf_mag;
  logic [15:0]       res_d;
  logic [3:0]        flg_d;

  fma16_lzc #(.SUM_W(SUM_W)) u_lzc (
    .sm_i  (sm_q),
    .lzc_o (lz)
  );

  // Left-shift distance: lzc capped by STEP and by e-1.
  always_comb begin
    lz8 = 8'(lz);
    em1 = $unsigned(e_q) - 8'd1;
    k_d = (lz8 < STEP8) ? lz8 : STEP8;
    if (em1 < k_d) k_d = em1;
  end

  // Round the normalized sum and pack the half result.
  always_comb begin
    m    = sm_q[SUM_W-1 -: 11];
    g    = sm_q[SUM_W-12];
    s    = (|sm_q[SUM_W-13:0]) | sticky_q;
    zero = ~(|sm_q) & ~sticky_q;
    inc  = 1'b0;
    ovf_mag = INF[14:0];
    unique case (rm_q)
      RZ: begin
        inc     = 1'b0;
        ovf_mag = MAXFIN[14:0];
      end
      RNE: begin
        inc     = g & (s | m[0]);
        ovf_mag = INF[14:0];
      end
      RM: begin
        inc     = ms_q & (g | s);
        ovf_mag = ms_q ? INF[14:0] : MAXFIN[14:0];
      end
      RP: begin
        inc     = ~ms_q & (g | s);
        ovf_mag = ms_q ? MAXFIN[14:0] : INF[14:0];
      end
    endcase
    msum = {1'b0, m} + {11'd0, inc};
    m_r  = msum[11] ? 11'h400 : msum[10:0];
    e_r  = {e_q[7], e_q} + {8'd0, msum[11]};
    res_d = {ms_q, (m_r[10] ? e_r[4:0] : 5'd0), m_r[9:0]};
    flg_d = '0;
    flg_d[FLG_NX] = g | s;
    flg_d[FLG_UF] = (g | s) & ~m[10];
    if (ovf_q || (!zero && e_r >= EOVF9)) begin
      res_d = {ms_q, ovf_mag};
      flg_d = '0;
      flg_d[FLG_OF] = 1'b1;
      flg_d[FLG_NX] = 1'b1;
    end else if (zero) begin
      res_d = {ms_q, 15'd0};
      flg_d = '0;
    end
  end

  // Control FSM with the datapath registers it sequences.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sm_q     <= '0;
      e_q      <= '0;
      ms_q     <= 1'b0;
      rm_q     <= RZ;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sm_q     <= sm;
            e_q      <= e_in;
            ms_q     <= ms;
            rm_q     <= roundmode;
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
            if (special) begin
              result_q <= special_res;
              flags_q  <= special_flags;
              state_q  <= OUT;
            end else begin
              state_q  <= NORM;
            end
          end
        end
        NORM: begin
          if (e_q >= EOVF8 && sm_q[SUM_W-1]) begin
            ovf_q   <= 1'b1;
            state_q <= ROUND;
          end else if (e_q < ECOL) begin
            sticky_q <= sticky_q | (|sm_q);
            sm_q     <= '0;
            e_q      <= 8'sd1;
          end else if (e_q < 8'sd1) begin
            sm_q     <= sm_q >> 1;
            sticky_q <= sticky_q | sm_q[0];
            e_q      <= e_q + 8'sd1;
          end else if (!sm_q[SUM_W-1] && e_q > 8'sd1 && (|sm_q)) begin
            sm_q <= sm_q << k_d;
            e_q  <= e_q - k_d;
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          result_q <= res_d;
          flags_q  <= flg_d;
          state_q  <= OUT;
        end
        OUT: begin
          if (out_ready) state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fma16_norm_round.sv
// Directed scoreboard bench for fma16_norm_round.
// Expected result, flags and latency are queued at drive time.
module tb_fma16_norm_round;

  localparam int SUM_W = 48;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SUM_W-1:0]  sm = '0;
  logic signed [7:0] e_in = '0;
  logic              ms = 1'b0;
  logic [1:0]        roundmode = 2'b01;
  logic              special = 1'b0;
  logic [15:0]       special_res = '0;
  logic [3:0]        special_flags = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [15:0]       result;
  logic [3:0]        flags;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    int          lat;
  } exp_t;

  exp_t sb[$];

  fma16_norm_round #(.SUM_W(SUM_W), .STEP(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .sm            (sm),
    .e_in          (e_in),
    .ms            (ms),
    .roundmode     (roundmode),
    .special       (special),
    .special_res   (special_res),
    .special_flags (special_flags),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .flags         (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input string tag, input logic [47:0] s,
                        input int e, input logic sg, input logic [1:0] rm,
                        input logic sp, input logic [15:0] sres,
                        input logic [3:0] sflg, input logic [15:0] xres,
                        input logic [3:0] xflg, input int xlat,
                        input int hold);
    exp_t x;
    exp_t got;
    int lat;
    x.res = xres;
    x.flg = xflg;
    x.lat = xlat;
    sb.push_back(x);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    sm = s;
    e_in = 8'(e);
    ms = sg;
    roundmode = rm;
    special = sp;
    special_res = sres;
    special_flags = sflg;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sm = 48'({$urandom(), $urandom()});
    e_in = 8'($urandom());
    ms = 1'($urandom());
    roundmode = 2'($urandom());
    special = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    got = sb.pop_front();
    chk({tag, "_res"}, 32'(result), 32'(got.res));
    chk({tag, "_flg"}, 32'(flags), 32'(got.flg));
    chk({tag, "_lat"}, 32'(lat), 32'(got.lat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_r"}, 32'(result), 32'(got.res));
      chk({tag, "_hold_f"}, 32'(flags), 32'(got.flg));
      chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_done_v"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(result), 32'd0);
    chk("rst_flg", 32'(flags), 32'd0);

    run_op("norm", 48'h8000_0000_0000, 15, 1'b0, 2'b01, 1'b0, 16'h0, 4'h0,
           16'h3C00, 4'b0000, 3, 5);
    run_op("cancel", 48'h0800_0000_0000, 19, 1'b0, 2'b01, 1'b0, 16'h0, 4'h0,
           16'h3C00, 4'b0000, 4, 0);
    run_op("tie_rne", 48'h8030_0000_0000, 15, 1'b0, 2'b01, 1'b0, 16'h0,
           4'h0, 16'h3C02, 4'b0001, 3, 0);
    run_op("tie_rz", 48'h8030_0000_0000, 15, 1'b0, 2'b00, 1'b0, 16'h0,
           4'h0, 16'h3C01, 4'b0001, 3, 0);
    run_op("tie_rp", 48'h8030_0000_0000, 15, 1'b0, 2'b11, 1'b0, 16'h0,
           4'h0, 16'h3C02, 4'b0001, 3, 0);
    run_op("tie_rm", 48'h8030_0000_0000, 15, 1'b0, 2'b10, 1'b0, 16'h0,
           4'h0, 16'h3C01, 4'b0001, 3, 0);
    run_op("ovf_rne", 48'h8000_0000_0000, 31, 1'b0, 2'b01, 1'b0, 16'h0,
           4'h0, 16'h7C00, 4'b0101, 3, 0);
    run_op("ovf_rz", 48'h8000_0000_0000, 31, 1'b0, 2'b00, 1'b0, 16'h0,
           4'h0, 16'h7BFF, 4'b0101, 3, 0);
    run_op("ovf_rm_neg", 48'h8000_0000_0000, 31, 1'b1, 2'b10, 1'b0, 16'h0,
           4'h0, 16'hFC00, 4'b0101, 3, 0);
    run_op("ovf_carry", 48'hFFF0_0000_0000, 30, 1'b0, 2'b01, 1'b0, 16'h0,
           4'h0, 16'h7C00, 4'b0101, 3, 0);
    run_op("sub_min", 48'h8000_0000_0000, -9, 1'b0, 2'b01, 1'b0, 16'h0,
           4'h0, 16'h0001, 4'b0000, 13, 0);
    run_op("sub_half", 48'h8000_0000_0000, -10, 1'b0, 2'b01, 1'b0, 16'h0,
           4'h0, 16'h0000, 4'b0011, 14, 0);
    run_op("collapse", 48'h8000_0000_0000, -40, 1'b0, 2'b01, 1'b0, 16'h0,
           4'h0, 16'h0000, 4'b0011, 4, 0);
    run_op("zero_neg", 48'h0, 5, 1'b1, 2'b01, 1'b0, 16'h0, 4'h0,
           16'h8000, 4'b0000, 3, 0);
    run_op("special", 48'h8000_0000_0000, 15, 1'b0, 2'b01, 1'b1, 16'h7E00,
           4'b1000, 16'h7E00, 4'b1000, 1, 0);

    @(negedge clk);
    in_valid = 1'b1;
    sm = 48'h8000_0000_0000;
    e_in = -8'sd9;
    ms = 1'b0;
    roundmode = 2'b01;
    special = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midnorm_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_rdy", 32'(in_ready), 32'd1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_res", 32'(result), 32'd0);
    chk("midrst_flg", 32'(flags), 32'd0);
    repeat (15) @(negedge clk);
    chk("midrst_quiet", 32'(out_valid), 32'd0);

    run_op("post_rst", 48'h8000_0000_0000, 15, 1'b1, 2'b01, 1'b0, 16'h0,
           4'h0, 16'hBC00, 4'b0000, 3, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
